// File: rtl/console_out_arbiter_if.sv
// Console byte channel shared by the cores and the arbiter.
// master: core side (requests); slave: arbiter side.
interface console_out_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           out_byte;
    logic                 out_byte_en;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    modport master (
        output req_valid, req_byte,
        input  req_ready, out_byte, out_byte_en, grant_id, busy
    );

    modport slave (
        input  req_valid, req_byte,
        output req_ready, out_byte, out_byte_en, grant_id, busy
    );
endinterface

// File: rtl/console_out_arbiter.sv
// Round-robin console arbiter; grant is held for a whole line
// (newline, burst limit or owner idle timeout releases it).
module console_out_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 16,
    parameter int IDW          = 2
) (
    input  logic clk,
    input  logic reset,
    console_out_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] rr_ptr, rr_nx;
    logic [IDW-1:0] grant_q, grant_nx;
    logic [BW-1:0]  burst_cnt, burst_nx;
    logic [TW-1:0]  idle_cnt, idle_nx;
    logic [7:0]     out_q, out_nx;
    logic           en_q, en_nx;
    logic [IDW-1:0] sel;
    logic           any;
    logic           own_valid;
    logic [7:0]     own_byte;
    logic           xfer;
    logic           rel;
    logic [NUM_REQ-1:0] ready;

    // First valid requester at or after rr_ptr, wrapping around
    always_comb begin
        int idx;
        any = 1'b0;
        sel = '0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && i == idx && bus.req_valid[i]) begin
                    any = 1'b1;
                    sel = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_byte  = 8'h00;
        ready     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                own_valid = bus.req_valid[i];
                own_byte  = bus.req_byte[8*i +: 8];
                ready[i]  = (state == LOCK);
            end
        end
    end

    assign xfer = (state == LOCK) && own_valid;

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        grant_nx = grant_q;
        burst_nx = burst_cnt;
        idle_nx  = idle_cnt;
        out_nx   = out_q;
        en_nx    = 1'b0;
        rel      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nx = LOCK;
                    grant_nx = sel;
                    burst_nx = '0;
                    idle_nx  = '0;
                end
            end
            LOCK: begin
                if (xfer) begin
                    out_nx   = own_byte;
                    en_nx    = 1'b1;
                    burst_nx = burst_cnt + 1'b1;
                    idle_nx  = '0;
                    rel = (own_byte == 8'h0A) ||
                          (burst_cnt == BW'(MAX_BURST - 1));
                end else begin
                    idle_nx = idle_cnt + 1'b1;
                    rel = (idle_cnt == TW'(IDLE_TIMEOUT - 1));
                end
                if (rel) begin
                    state_nx = IDLE;
                    rr_nx    = IDW'((int'(grant_q) + 1) % NUM_REQ);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            out_q     <= 8'h00;
            en_q      <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            grant_q   <= grant_nx;
            burst_cnt <= burst_nx;
            idle_cnt  <= idle_nx;
            out_q     <= out_nx;
            en_q      <= en_nx;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.out_byte    = out_q;
    assign bus.out_byte_en = en_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = (state == LOCK);
endmodule
